// File: rtl/vc_flow_tx.sv
// Two-virtual-channel transmitter in front of one switch port.
// It keeps one FIFO per VC, arbitrates round-robin and obeys per-VC pause/continue.
module vc_flow_tx #(
  parameter int BUS_SIZE   = 5,
  parameter int ADDR_WIDTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [BUS_SIZE:0] wr_data,
  input  logic              pause_vc0,
  input  logic              pause_vc1,
  input  logic              continue_vc0,
  input  logic              continue_vc1,
  output logic [BUS_SIZE:0] data_out,
  output logic              valid_out,
  output logic              full_vc0,
  output logic              full_vc1,
  output logic              idle,
  output logic              active,
  output logic              error
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int W     = BUS_SIZE + 1;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, STALL} state_e;

  state_e state_q, state_d;

  logic [W-1:0]                 mem_q [2][DEPTH];
  logic [1:0][ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0][ADDR_WIDTH:0]     count_q, count_d;
  logic [1:0]                   blk_q, blk_d;
  logic                         last_vc_q, last_vc_d;
  logic [W-1:0]                 data_out_q, data_out_d;
  logic                         valid_q, valid_d;
  logic                         error_q, error_d;

  logic [1:0] pause, cont, full, elig, push, pop;
  logic       wr_vc, grant_valid, grant_vc;

  assign pause = {pause_vc1, pause_vc0};
  assign cont  = {continue_vc1, continue_vc0};
  assign wr_vc = wr_data[BUS_SIZE];

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    full        = '0;
    elig        = '0;
    push        = '0;
    pop         = '0;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    blk_d       = blk_q;
    for (int v = 0; v < 2; v++) begin
      full[v] = (count_q[v] == FULL_CNT);
      // Same-cycle pause already suppresses the pop, before blk catches up.
      elig[v] = (count_q[v] != '0) && !blk_q[v] && !pause[v];
      push[v] = wr_en && (wr_vc == 1'(v)) && !full[v];
      blk_d[v] = pause[v] | (blk_q[v] & ~cont[v]);
    end

    grant_valid = |elig;
    grant_vc    = (elig == 2'b11) ? ~last_vc_q : elig[1];
    for (int v = 0; v < 2; v++) begin
      pop[v] = grant_valid && (grant_vc == 1'(v));
      if (push[v]) wr_ptr_d[v] = wr_ptr_q[v] + 1'b1;
      if (pop[v])  rd_ptr_d[v] = rd_ptr_q[v] + 1'b1;
      case ({push[v], pop[v]})
        2'b10:   count_d[v] = count_q[v] + 1'b1;
        2'b01:   count_d[v] = count_q[v] - 1'b1;
        default: count_d[v] = count_q[v];
      endcase
    end

    last_vc_d  = grant_valid ? grant_vc : last_vc_q;
    data_out_d = grant_valid ? mem_q[grant_vc][rd_ptr_q[grant_vc]] : data_out_q;
    valid_d    = grant_valid;
    // Full is judged on the pre-edge count, so a pop of the same FIFO does not make room.
    error_d    = error_q | (wr_en && full[wr_vc]);
  end

  always_comb begin
    if (grant_valid)           state_d = SEND;
    else if (count_d != '0)    state_d = STALL;
    else                       state_d = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      blk_q      <= '0;
      last_vc_q  <= 1'b1;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      blk_q      <= blk_d;
      last_vc_q  <= last_vc_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
    end
  end

  // NOTE: storage is not reset; empty counts make stale entries unreachable.
  always_ff @(posedge clk) begin
    for (int v = 0; v < 2; v++) begin
      if (push[v]) mem_q[v][wr_ptr_q[v]] <= wr_data;
    end
  end

  always_comb begin
    idle   = (state_q == IDLE);
    active = (state_q == SEND);
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_q;
  assign full_vc0  = full[0];
  assign full_vc1  = full[1];
  assign error     = error_q;

endmodule
